// File: rtl/wb_csr_bank.sv
// Wishbone control/status register bank: 2**ADRBITS registers, each read/write control,
// sticky write-1-to-clear status, or plain read-only input, selected by RWMASK/STICKYMASK.
module wb_csr_bank #(
  parameter int                             ADRBITS    = 2,
  parameter int                             DW         = 16,
  parameter logic [(2**ADRBITS)-1:0]        RWMASK     = '0,
  parameter logic [(2**ADRBITS)-1:0]        STICKYMASK = '0,
  parameter logic [DW*(2**ADRBITS)-1:0]     PULSEMASK  = '0,
  parameter logic [DW*(2**ADRBITS)-1:0]     RSTVAL     = '0
) (
  input  logic                              wb_clk,
  input  logic                              wb_rst,
  input  logic                              wb_cyc,
  input  logic                              wb_stb,
  input  logic                              wb_we,
  input  logic [ADRBITS-1:0]                wb_adr,
  input  logic [DW-1:0]                     wb_dat_i,
  output logic [DW-1:0]                     wb_dat_o,
  output logic                              wb_ack,
  input  logic [DW*(2**ADRBITS)-1:0]        reg_i,
  output logic [DW*(2**ADRBITS)-1:0]        reg_o,
  output logic [(2**ADRBITS)-1:0]           wr_strobe
);

  localparam int N = 2**ADRBITS;

  logic                acc;
  logic                wr;
  logic [DW-1:0]       rd_val;
  logic [DW*N-1:0]     reg_q;

  assign acc   = wb_cyc & wb_stb & ~wb_ack;
  assign wr    = acc & wb_we;
  assign reg_o = reg_q;

  // Read-only slots hold zero in reg_q, so their read data comes straight from reg_i.
  always_comb begin
    rd_val = reg_i[int'(wb_adr)*DW +: DW];
    if (RWMASK[wb_adr] | STICKYMASK[wb_adr])
      rd_val = reg_q[int'(wb_adr)*DW +: DW];
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack    <= 1'b0;
      wb_dat_o  <= '0;
      wr_strobe <= '0;
    end else begin
      wb_ack    <= acc;
      wr_strobe <= '0;
      if (wr)
        wr_strobe[wb_adr] <= 1'b1;
      if (acc)
        wb_dat_o <= rd_val;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_reg
    localparam logic [DW-1:0] RST_I   = RSTVAL[DW*i +: DW];
    localparam logic [DW-1:0] PULSE_I = PULSEMASK[DW*i +: DW];

    if (RWMASK[i]) begin : g_ctl
      logic          hit;
      logic [DW-1:0] q;

      assign hit                 = wr && (wb_adr == ADRBITS'(i));
      assign reg_q[DW*i +: DW]   = q;

      // Pulse bits survive only the cycle after the write, then self-clear.
      always_ff @(posedge wb_clk) begin
        if (wb_rst)
          q <= RST_I & ~PULSE_I;
        else if (hit)
          q <= wb_dat_i;
        else
          q <= q & ~PULSE_I;
      end
    end else if (STICKYMASK[i]) begin : g_sticky
      logic          hit;
      logic [DW-1:0] clr;
      logic [DW-1:0] q;

      assign hit                 = wr && (wb_adr == ADRBITS'(i));
      assign clr                 = hit ? wb_dat_i : '0;
      assign reg_q[DW*i +: DW]   = q;

      // A set arriving on the clearing cycle wins.
      always_ff @(posedge wb_clk) begin
        if (wb_rst)
          q <= '0;
        else
          q <= (q & ~clr) | reg_i[DW*i +: DW];
      end
    end else begin : g_ro
      assign reg_q[DW*i +: DW] = '0;
    end
  end

endmodule

// File: tb/tb_wb_csr_bank.sv
// Scoreboard bench for wb_csr_bank: two control registers (one with a pulse bit), one sticky, one read-only.
module tb_wb_csr_bank;

  logic        wb_clk;
  logic        wb_rst;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [1:0]  wb_adr;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack;
  logic [63:0] reg_i;
  logic [63:0] reg_o;
  logic [3:0]  wr_strobe;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [15:0] sbQ[$];
  logic [15:0] ctl0Model;
  logic [15:0] randVal;

  wb_csr_bank #(
    .ADRBITS   (2),
    .DW        (16),
    .RWMASK    (4'b0011),
    .STICKYMASK(4'b0100),
    .PULSEMASK (64'h0000_0000_8000_0000),
    .RSTVAL    (64'h0000_0000_0000_00A5)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack   (wb_ack),
    .reg_i    (reg_i),
    .reg_o    (reg_o),
    .wr_strobe(wr_strobe)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every ack pops the oldest expected read value.
  always @(negedge wb_clk) begin
    if (wb_ack === 1'b1) begin
      if (sbQ.size() == 0)
        checkOutput("sb_unexpected_ack", 64'(sbQ.size()), 64'd1);
      else
        checkOutput("sb_rdata", {48'd0, wb_dat_o}, {48'd0, sbQ.pop_front()});
    end
  end

  // Single access; returns at the negedge where the ack is expected.
  task automatic applyStimulus(input logic we, input logic [1:0] adr, input logic [15:0] data,
                               input logic [15:0] expRd, input logic [3:0] expStrobe);
    @(negedge wb_clk);
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_adr   = adr;
    wb_dat_i = data;
    sbQ.push_back(expRd);
    @(negedge wb_clk);
    checkOutput("ack_latency", {63'd0, wb_ack}, 64'd1);
    checkOutput("wr_strobe", {60'd0, wr_strobe}, {60'd0, expStrobe});
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  initial begin
    wb_rst   = 1'b1;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_adr   = '0;
    wb_dat_i = '0;
    reg_i    = '0;

    repeat (2) @(negedge wb_clk);
    checkOutput("rst_ack", {63'd0, wb_ack}, 64'd0);
    checkOutput("rst_dat_o", {48'd0, wb_dat_o}, 64'd0);
    checkOutput("rst_strobe", {60'd0, wr_strobe}, 64'd0);
    checkOutput("rst_reg_o", reg_o, 64'h0000_0000_0000_00A5);
    wb_rst = 1'b0;

    $display("[TB] reset reads");
    applyStimulus(1'b0, 2'd0, 16'h0, 16'h00A5, 4'b0000);
    applyStimulus(1'b0, 2'd1, 16'h0, 16'h0000, 4'b0000);

    $display("[TB] control write");
    applyStimulus(1'b1, 2'd0, 16'h1234, 16'h00A5, 4'b0001);
    checkOutput("ctl0_reg_o", {48'd0, reg_o[15:0]}, 64'h1234);
    @(negedge wb_clk);
    checkOutput("strobe_clear", {60'd0, wr_strobe}, 64'd0);
    applyStimulus(1'b0, 2'd0, 16'h0, 16'h1234, 4'b0000);
    ctl0Model = 16'h1234;

    $display("[TB] pulse bit");
    applyStimulus(1'b1, 2'd1, 16'h8001, 16'h0000, 4'b0010);
    checkOutput("pulse_high", {48'd0, reg_o[31:16]}, 64'h8001);
    @(negedge wb_clk);
    checkOutput("pulse_cleared", {48'd0, reg_o[31:16]}, 64'h0001);
    applyStimulus(1'b0, 2'd1, 16'h0, 16'h0001, 4'b0000);

    $display("[TB] sticky status");
    @(negedge wb_clk);
    reg_i[47:32] = 16'h0010;
    @(negedge wb_clk);
    reg_i[47:32] = 16'h0000;
    checkOutput("sticky_reg_o", {48'd0, reg_o[47:32]}, 64'h0010);
    applyStimulus(1'b0, 2'd2, 16'h0, 16'h0010, 4'b0000);
    applyStimulus(1'b1, 2'd2, 16'h0010, 16'h0010, 4'b0100);
    applyStimulus(1'b0, 2'd2, 16'h0, 16'h0000, 4'b0000);
    reg_i[47:32] = 16'h0010;
    @(negedge wb_clk);
    applyStimulus(1'b1, 2'd2, 16'h0010, 16'h0010, 4'b0100);
    applyStimulus(1'b0, 2'd2, 16'h0, 16'h0010, 4'b0000);
    reg_i[47:32] = 16'h0000;
    applyStimulus(1'b1, 2'd2, 16'h0010, 16'h0010, 4'b0100);
    applyStimulus(1'b0, 2'd2, 16'h0, 16'h0000, 4'b0000);

    $display("[TB] read-only input");
    reg_i[63:48] = 16'hBEEF;
    applyStimulus(1'b0, 2'd3, 16'h0, 16'hBEEF, 4'b0000);
    checkOutput("ro_reg_o", {48'd0, reg_o[63:48]}, 64'd0);
    applyStimulus(1'b1, 2'd3, 16'h1111, 16'hBEEF, 4'b1000);
    checkOutput("ro_reg_o_after_wr", {48'd0, reg_o[63:48]}, 64'd0);
    applyStimulus(1'b0, 2'd3, 16'h0, 16'hBEEF, 4'b0000);

    $display("[TB] random control writes");
    for (int k = 0; k < 4; k++) begin
      randVal = 16'($urandom);
      applyStimulus(1'b1, 2'd0, randVal, ctl0Model, 4'b0001);
      ctl0Model = randVal;
      applyStimulus(1'b0, 2'd0, 16'h0, ctl0Model, 4'b0000);
    end

    $display("[TB] held strobe");
    @(negedge wb_clk);
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = 1'b0;
    wb_adr = 2'd0;
    for (int k = 0; k < 3; k++) sbQ.push_back(ctl0Model);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("ack_pattern_%0d", k), {63'd0, wb_ack}, 64'(k % 2));
      if (k < 5) @(negedge wb_clk);
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;

    $display("[TB] reset during access");
    @(negedge wb_clk);
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = 1'b1;
    wb_adr   = 2'd0;
    wb_dat_i = 16'h5555;
    wb_rst   = 1'b1;
    @(negedge wb_clk);
    checkOutput("rst_mid_ack", {63'd0, wb_ack}, 64'd0);
    checkOutput("rst_mid_ctl0", {48'd0, reg_o[15:0]}, 64'h00A5);
    wb_rst = 1'b0;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    @(negedge wb_clk);
    checkOutput("rst_mid_no_ack", {63'd0, wb_ack}, 64'd0);
    applyStimulus(1'b0, 2'd0, 16'h0, 16'h00A5, 4'b0000);

    repeat (2) @(negedge wb_clk);
    checkOutput("sb_drain", 64'(sbQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
